// File: rtl/resta_pf_seq_if.sv
// resta_pf_seq_if: operand and result channels of the multi-cycle float subtractor.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer keeps valid and its payload
// stable until the transfer; ready may rise or fall freely. in_ready is high
// only while the block is idle. out_valid stays high, with result stable,
// until out_ready is seen.
interface resta_pf_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   // Producer/consumer side (testbench or surrounding datapath)
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   // Subtractor side
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/resta_pf_seq.sv
// resta_pf_seq: iterative IEEE-754 single-precision subtractor, result = a - b,
// round-toward-zero. b's sign is flipped at capture so the core is an adder.
// One alignment or normalisation shift per cycle.
// Optional build macro PF_SPECIAL_EN: decode exponent-255 inputs (NaN/inf)
// and produce inf on overflow; without it exp 255 is an ordinary exponent
// and overflow saturates to the largest finite value.
module resta_pf_seq #(
   parameter int MAX_ALIGN = 27
) (
   input  logic           clk,
   input  logic           rst_n,
   resta_pf_seq_if.slave  bus,
   output logic [2:0]     dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_ALIGN  = 3'd2,
      S_ADD    = 3'd3,
      S_NORM   = 3'd4,
      S_PACK   = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [7:0] CAP = 8'(MAX_ALIGN);

   // Significand layout (28 bits): [27] carry, [26] hidden, [25:3] fraction,
   // [2:0] guard/round/sticky.
   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;          // sign already inverted
   logic        s1_q, s1_d;
   logic        s2_q, s2_d;
   logic [9:0]  e1_q, e1_d;        // wide enough for the carry increment
   logic [27:0] m1_q, m1_d;
   logic [27:0] m2_q, m2_d;
   logic [7:0]  diff_q, diff_d;
   logic [31:0] result_q, result_d;

   // Unpack decode of the captured operands
   logic [7:0]  ea, eb, e_big, e_small, raw_diff;
   logic [27:0] sig_a, sig_b, m_big, m_small;
   logic [30:0] mag_a, mag_b;
   logic        a_ge_b, s_big, s_small;

   // Decode both operands, flush exponent-0 values to zero and order by magnitude
   always_comb begin
      ea       = a_q[30:23];
      eb       = b_q[30:23];
      sig_a    = (ea == 8'd0) ? 28'd0 : {2'b01, a_q[22:0], 3'b000};
      sig_b    = (eb == 8'd0) ? 28'd0 : {2'b01, b_q[22:0], 3'b000};
      mag_a    = {ea, (ea == 8'd0) ? 23'd0 : a_q[22:0]};
      mag_b    = {eb, (eb == 8'd0) ? 23'd0 : b_q[22:0]};
      a_ge_b   = (mag_a >= mag_b);
      s_big    = a_ge_b ? a_q[31] : b_q[31];
      s_small  = a_ge_b ? b_q[31] : a_q[31];
      e_big    = a_ge_b ? ea : eb;
      e_small  = a_ge_b ? eb : ea;
      m_big    = a_ge_b ? sig_a : sig_b;
      m_small  = a_ge_b ? sig_b : sig_a;
      raw_diff = e_big - e_small;
   end

`ifdef PF_SPECIAL_EN
   logic        is_spec;
   logic [31:0] spec_val;
   logic        a_nan, b_nan, a_inf, b_inf;

   // Classify NaN/inf operands; the result is fixed without any arithmetic
   always_comb begin
      a_nan   = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
      b_nan   = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
      a_inf   = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
      b_inf   = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
      is_spec = (ea == 8'hFF) || (eb == 8'hFF);
      if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31])))
         spec_val = 32'h7FC0_0000;
      else if (a_inf)
         spec_val = {a_q[31], 31'h7F80_0000};
      else
         spec_val = {b_q[31], 31'h7F80_0000};
   end
`endif

   // Next-state and datapath updates for every FSM state
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      e1_d     = e1_q;
      m1_d     = m1_q;
      m2_d     = m2_q;
      diff_d   = diff_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = {~bus.b[31], bus.b[30:0]};
               state_d = S_UNPACK;
            end
         end

         S_UNPACK: begin
            s1_d = s_big;
            s2_d = s_small;
            e1_d = {2'b00, e_big};
            m1_d = m_big;
            if (raw_diff > CAP) begin
               // Too far below op1 to matter except as a sticky contribution
               diff_d = CAP;
               m2_d   = {27'd0, |m_small};
            end else begin
               diff_d = raw_diff;
               m2_d   = m_small;
            end
            state_d = (diff_d != 8'd0) ? S_ALIGN : S_ADD;
`ifdef PF_SPECIAL_EN
            if (is_spec)
               state_d = S_PACK;
`endif
         end

         S_ALIGN: begin
            m2_d   = {1'b0, m2_q[27:2], m2_q[1] | m2_q[0]};
            diff_d = diff_q - 8'd1;
            if (diff_q == 8'd1)
               state_d = S_ADD;
         end

         S_ADD: begin
            // op1 >= op2 in magnitude, so the difference cannot go negative
            m1_d    = (s1_q == s2_q) ? (m1_q + m2_q) : (m1_q - m2_q);
            state_d = S_NORM;
         end

         S_NORM: begin
            if (m1_q[27]) begin
               m1_d    = {1'b0, m1_q[27:2], m1_q[1] | m1_q[0]};
               e1_d    = e1_q + 10'd1;
               state_d = S_PACK;
            end else if (m1_q == 28'd0) begin
               // Exact cancellation is always +0
               s1_d    = 1'b0;
               e1_d    = 10'd0;
               state_d = S_PACK;
            end else if (m1_q[26]) begin
               state_d = S_PACK;
            end else if (e1_q > 10'd1) begin
               m1_d = m1_q << 1;
               e1_d = e1_q - 10'd1;
            end else begin
               // Would be denormal: flush, keeping the sign
               m1_d    = 28'd0;
               e1_d    = 10'd0;
               state_d = S_PACK;
            end
         end

         S_PACK: begin
            if (e1_q >= 10'd255) begin
`ifdef PF_SPECIAL_EN
               result_d = {s1_q, 31'h7F80_0000};
`else
               result_d = {s1_q, 31'h7F7F_FFFF};
`endif
            end else begin
               result_d = {s1_q, e1_q[7:0], m1_q[25:3]};
            end
`ifdef PF_SPECIAL_EN
            if (is_spec)
               result_d = spec_val;
`endif
            state_d = S_DONE;
         end

         S_DONE: begin
            if (bus.out_ready)
               state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         e1_q     <= 10'd0;
         m1_q     <= 28'd0;
         m2_q     <= 28'd0;
         diff_q   <= 8'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         e1_q     <= e1_d;
         m1_q     <= m1_d;
         m2_q     <= m2_d;
         diff_q   <= diff_d;
         result_q <= result_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_resta_pf_seq.sv
// tb_resta_pf_seq: table of hand-computed subtractions with expected result
// and capture-to-out_valid latency, plus handshake-hold and mid-op reset
// sequences.
module tb_resta_pf_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   resta_pf_seq_if bus();

   resta_pf_seq #(.MAX_ALIGN(27)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          lat;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   int          lat_q[$];
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, got, want);
      end
   endtask

   function automatic void add_vec(input string nm, input logic [31:0] av, input logic [31:0] bv,
                                   input logic [31:0] rv, input int lv);
      vec_t v;
      v.name = nm; v.a = av; v.b = bv; v.r = rv; v.lat = lv;
      vecs.push_back(v);
   endfunction

   // Drive one operation, wait for its result, optionally stall the consumer.
   task automatic do_op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] rv, input int lv, input int hold);
      int          n;
      logic [31:0] want, held;
      int          wlat;
      chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.a        = av;
      bus.b        = bv;
      bus.in_valid = 1'b1;
      exp_q.push_back(rv);
      lat_q.push_back(lv);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         n++;
         #1;
         if (bus.out_valid) break;
      end
      want = exp_q.pop_front();
      wlat = lat_q.pop_front();
      if (!bus.out_valid) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: out_valid=0 after %0d cycles, want result %h", nm, n, want);
         rst_n = 1'b0;
         #2 rst_n = 1'b1;
         return;
      end
      chk({nm, "_lat"}, 32'(n), 32'(wlat));
      chk({nm, "_result"}, bus.result, want);
      held = bus.result;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk({nm, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         chk({nm, "_hold_result"}, bus.result, held);
         chk({nm, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk({nm, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({nm, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
      chk({nm, "_result_kept"}, bus.result, want);
   endtask

   initial begin
      int seen;

      // Latencies: 4 + capped exponent difference + left-normalisation shifts
      add_vec("5m3",       32'h40A0_0000, 32'h4040_0000, 32'h4000_0000, 6);  // exps differ by 1, 1 shift
      add_vec("3m5",       32'h4040_0000, 32'h40A0_0000, 32'hC000_0000, 6);
      add_vec("carry",     32'hC2C8_8000, 32'h42C8_8000, 32'hC348_8000, 4);
      add_vec("1m1",       32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4);
      add_vec("cap_stky",  32'h3F80_0000, 32'h3080_0000, 32'h3F7F_FFFF, 32);
      add_vec("1mneg1",    32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4);
      add_vec("0m1",       32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 31);
      add_vec("2m1",       32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 6);
      add_vec("1m2",       32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 6);
      add_vec("1p5m1",     32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000, 5);
      add_vec("ulp",       32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000, 27);
      add_vec("denorm",    32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 4);
      add_vec("uflow_pos", 32'h00C0_0000, 32'h0080_0000, 32'h0000_0000, 4);
      add_vec("uflow_neg", 32'h80C0_0000, 32'h8080_0000, 32'h8000_0000, 4);
`ifdef PF_SPECIAL_EN
      add_vec("inf_m_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 2);
      add_vec("ovf_inf",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4);
      add_vec("inf_m_1",   32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 2);
      add_vec("nan",       32'h7FC0_0001, 32'h0000_0000, 32'h7FC0_0000, 2);
      add_vec("ninf_minf", 32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000, 2);
`else
      add_vec("e255_same", 32'h7F80_0000, 32'h7F80_0000, 32'h0000_0000, 4);
      add_vec("ovf_sat",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F7F_FFFF, 4);
      add_vec("ovf_satn",  32'hFF7F_FFFF, 32'h7F7F_FFFF, 32'hFF7F_FFFF, 4);
`endif

      bus.in_valid  = 1'b0;
      bus.a         = 32'd0;
      bus.b         = 32'd0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result",    bus.result, 32'd0);
      chk("rst_busy",      32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i])
         do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, 0);

      // Result held with consumer stalled for 3 cycles
      do_op("stall", 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4, 3);

      // Reset in the middle of alignment (exponent difference 23)
      bus.a        = 32'h4B00_0000;
      bus.b        = 32'h3F80_0000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_in_align", 32'(dbg_state), 32'd2);
      chk("abort_busy",     32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #2;
      chk("abort_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_rst_busy",     32'(bus.busy), 32'd0);
      chk("abort_rst_result",   bus.result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      chk("abort_no_valid",  32'(seen), 32'd0);
      chk("abort_in_ready",  32'(bus.in_ready), 32'd1);
      do_op("after_abort", 32'h40A0_0000, 32'h4040_0000, 32'h4000_0000, 6, 0);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
